// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the N-channel audio mixer: FSM state encoding,
// accumulator sizing and unsigned saturation.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        FILT  = 2'd3
    } mix_state_t;

    localparam int SAT_MAX_W = 64;

    // Wide enough that NUM_CH full-scale products can never wrap.
    function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
        return in_w + gain_w + $clog2(num_ch);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_u(input logic [SAT_MAX_W-1:0] value,
                                                   input int width);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/audio_lp_shift.sv
// One-pole low-pass filter with a power-of-two coefficient, updated only when en is high.
// SHIFT = 0 degenerates to a registered pass-through.
module audio_lp_shift
    import audio_mix_pkg::*;
#(
    parameter int W     = 16,
    parameter int SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] dout_reg;

    generate
        if (SHIFT == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (en) begin
                    dout_reg <= din;
                end
            end
        end else begin : g_filter
            localparam int S_W = W + SHIFT;

            logic [S_W-1:0] s_reg;
            logic [S_W:0]   sum_ext;
            logic [S_W-1:0] s_next;

            // s - (s >> SHIFT) + din never goes negative and never exceeds 2^S_W-1.
            always_comb begin
                sum_ext = {1'b0, s_reg} + (S_W + 1)'(din) - (S_W + 1)'(s_reg >> SHIFT);
                s_next  = sum_ext[S_W-1:0];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_reg    <= '0;
                    dout_reg <= '0;
                end else if (en) begin
                    s_reg    <= s_next;
                    dout_reg <= W'(s_next >> SHIFT);
                end
            end
        end
    endgenerate

    assign dout = dout_reg;

endmodule

// File: rtl/audio_mixer_nch.sv
// N-channel audio mixer: snapshot on sample tick, serial gain-weighted accumulate,
// saturate, click-free mute ramp, then a one-pole low-pass filter.
module audio_mixer_nch
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int GAIN_W     = 8,
    parameter int RAMP_W     = 4,
    parameter int FILT_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_en,
    input  logic [NUM_CH-1:0][IN_W-1:0]    ch_in,
    input  logic [NUM_CH-1:0][GAIN_W-1:0]  ch_gain,
    input  logic [NUM_CH-1:0]              ch_mask,
    input  logic                           sound_enable,
    input  logic                           force_on,
    output logic [OUT_W-1:0]               out,
    output logic                           out_valid,
    output logic                           clip,
    output logic                           overrun
);

    localparam int ACC_W = acc_width(IN_W, GAIN_W, NUM_CH);
    localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = RAMP_W + 1;
    localparam int MA_W  = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int MB_W  = (GAIN_W > LVL_W) ? GAIN_W : LVL_W;
    localparam int P_W   = MA_W + MB_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(1) << RAMP_W;

    mix_state_t state_reg, state_next;

    logic [IN_W-1:0]   snap_in   [NUM_CH];
    logic [GAIN_W-1:0] snap_gain [NUM_CH];
    logic              snap_mask [NUM_CH];

    logic [CNT_W-1:0]  idx_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [OUT_W-1:0]  v_reg;
    logic              clip_pend_reg;
    logic              out_valid_reg;
    logic              clip_reg;
    logic              overrun_reg;

    logic              accept;
    logic [MA_W-1:0]   mul_a;
    logic [MB_W-1:0]   mul_b;
    logic [P_W-1:0]    product;
    logic [SAT_MAX_W-1:0] m_raw;
    logic [SAT_MAX_W-1:0] m_full;
    logic [OUT_W-1:0]  m_sat;
    logic              clip_now;

    assign accept = (state_reg == IDLE) && sample_en;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sample_en) state_next = ACCUM;
            ACCUM:   if (idx_reg == CNT_W'(NUM_CH - 1)) state_next = SCALE;
            SCALE:   state_next = FILT;
            FILT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_snap
            always_ff @(posedge clk) begin
                if (rst) begin
                    snap_in[gi]   <= '0;
                    snap_gain[gi] <= '0;
                    snap_mask[gi] <= 1'b0;
                end else if (accept) begin
                    snap_in[gi]   <= ch_in[gi];
                    snap_gain[gi] <= ch_gain[gi];
                    snap_mask[gi] <= ch_mask[gi];
                end
            end
        end
    endgenerate

    // Saturate the gain-normalised sum before it meets the mute level.
    always_comb begin
        m_raw    = SAT_MAX_W'(acc_reg) >> (GAIN_W - 1);
        m_full   = sat_u(m_raw, OUT_W);
        m_sat    = m_full[OUT_W-1:0];
        clip_now = (m_raw != m_full);
    end

    // Single multiplier: gain product during ACCUM, mute product during SCALE.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_reg == ACCUM) begin
            if (snap_mask[idx_reg]) begin
                mul_a = MA_W'(snap_in[idx_reg]);
                mul_b = MB_W'(snap_gain[idx_reg]);
            end
        end else if (state_reg == SCALE) begin
            mul_a = MA_W'(m_sat);
            mul_b = MB_W'(level_reg);
        end
        product = P_W'(mul_a) * P_W'(mul_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= '0;
            acc_reg <= '0;
        end else if (accept) begin
            idx_reg <= '0;
            acc_reg <= '0;
        end else if (state_reg == ACCUM) begin
            idx_reg <= idx_reg + CNT_W'(1);
            acc_reg <= acc_reg + ACC_W'(product);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg <= '0;
        end else if (accept) begin
            if (sound_enable || force_on) begin
                if (level_reg < LVL_FULL) level_reg <= level_reg + LVL_W'(1);
            end else if (level_reg != '0) begin
                level_reg <= level_reg - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg         <= '0;
            clip_pend_reg <= 1'b0;
        end else if (state_reg == SCALE) begin
            v_reg         <= OUT_W'(product >> RAMP_W);
            clip_pend_reg <= clip_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            clip_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= (state_reg == FILT);
            clip_reg      <= (state_reg == FILT) && clip_pend_reg;
            overrun_reg   <= sample_en && (state_reg != IDLE);
        end
    end

    audio_lp_shift #(
        .W     (OUT_W),
        .SHIFT (FILT_SHIFT)
    ) u_lp (
        .clk  (clk),
        .rst  (rst),
        .en   (state_reg == FILT),
        .din  (v_reg),
        .dout (out)
    );

    assign out_valid = out_valid_reg;
    assign clip      = clip_reg;
    assign overrun   = overrun_reg;

endmodule
